// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Double-buffered display data is committed only at frame boundaries or while idle.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 8,
    localparam int DW        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [3:0]              code_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [DW-1:0]           digit_o,
    output logic                    frame_o,
    output logic                    pending_o
);

    localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_e;

    state_e                  state_q, state_d;
    logic [DW-1:0]           digit_q, digit_d, digit_nxt;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              code_q, code_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;
    logic                    commit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d     = state_q;
        digit_d     = digit_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        dp_d        = dp_q;
        an_d        = '1;
        frame_d     = 1'b0;
        digit_nxt   = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;

        // Commit on the edge that closes a frame, or at any edge while idle.
        commit      = pending_q && (frame_q || state_q == S_IDLE);
        act_data_d  = commit ? sh_data_q  : act_data_q;
        act_blank_d = commit ? sh_blank_q : act_blank_q;
        act_dp_d    = commit ? sh_dp_q    : act_dp_q;
        sh_data_d   = load_i ? data_i  : sh_data_q;
        sh_blank_d  = load_i ? blank_i : sh_blank_q;
        sh_dp_d     = load_i ? dp_i    : sh_dp_q;
        pending_d   = load_i || (pending_q && !commit);

        if (!en_i) begin
            state_d = S_IDLE;
            digit_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_SHOW;
                    digit_d = '0;
                    cnt_d   = '0;
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = S_GAP;
                        end else begin
                            digit_d = digit_nxt;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_SHOW;
                        digit_d = digit_nxt;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    digit_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are derived from the next state so they line up with it once registered.
        if (state_d == S_SHOW) begin
            code_d = act_data_d[4*digit_d +: 4];
            dp_d   = ~act_dp_d[digit_d];
            if (!act_blank_d[digit_d]) begin
                an_d[digit_d] = 1'b0;
            end
        end

        if (GAP_CYCLES > 0) begin
            frame_d = (state_d == S_GAP)  && (digit_d == DIGIT_LAST) && (cnt_d == GAP_LAST);
        end else begin
            frame_d = (state_d == S_SHOW) && (digit_d == DIGIT_LAST) && (cnt_d == SHOW_LAST);
        end
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            digit_q     <= '0;
            cnt_q       <= '0;
            sh_data_q   <= '0;
            sh_blank_q  <= '0;
            sh_dp_q     <= '0;
            act_data_q  <= '0;
            act_blank_q <= '1;
            act_dp_q    <= '0;
            pending_q   <= 1'b0;
            code_q      <= '0;
            dp_q        <= 1'b1;
            an_q        <= '1;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            cnt_q       <= cnt_d;
            sh_data_q   <= sh_data_d;
            sh_blank_q  <= sh_blank_d;
            sh_dp_q     <= sh_dp_d;
            act_data_q  <= act_data_d;
            act_blank_q <= act_blank_d;
            act_dp_q    <= act_dp_d;
            pending_q   <= pending_d;
            code_q      <= code_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign code_o    = code_q;
    assign dp_o      = dp_q;
    assign an_o      = an_q;
    assign digit_o   = digit_q;
    assign frame_o   = frame_q;
    assign pending_o = pending_q;

endmodule
